// File: rtl/alu_arbiter_if.sv
// Request/response handshake bundle between the two requesters and alu_arbiter.
// Requester n occupies slice n of every packed request field.
interface alu_arbiter_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_REQ = 2
);
    logic [NUM_REQ-1:0]      req_valid_i;
    logic [NUM_REQ-1:0]      req_ready_o;
    logic [NUM_REQ*XLEN-1:0] req_data1_i;
    logic [NUM_REQ*XLEN-1:0] req_data2_i;
    logic [NUM_REQ*7-1:0]    req_opcode_i;
    logic [NUM_REQ*3-1:0]    req_func3_i;
    logic [NUM_REQ*7-1:0]    req_func7_i;
    logic [NUM_REQ-1:0]      rsp_valid_o;
    logic [NUM_REQ-1:0]      rsp_ready_i;
    logic [XLEN-1:0]         rsp_result_o;

    modport slave (
        input  req_valid_i, req_data1_i, req_data2_i, req_opcode_i, req_func3_i, req_func7_i,
        input  rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_result_o
    );

    modport master (
        output req_valid_i, req_data1_i, req_data2_i, req_opcode_i, req_func3_i, req_func7_i,
        output rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_result_o
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational alu between two requesters.
// One operation in flight: accept in IDLE, drive alu in EXEC, hold result in RESP.
module alu_arbiter #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_REQ = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    alu_arbiter_if.slave    bus,
    output logic [XLEN-1:0] alu_data1_o,
    output logic [XLEN-1:0] alu_data2_o,
    output logic [6:0]      alu_opcode_o,
    output logic [2:0]      alu_func3_o,
    output logic [6:0]      alu_func7_o,
    input  logic [XLEN-1:0] alu_result_i
);
    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e            r_state, w_state_next;
    logic [IdxW-1:0]   r_owner, r_last_grant, w_gnt_idx;
    logic              w_gnt_valid;
    logic [XLEN-1:0]   r_data1, r_data2, r_result;
    logic [6:0]        r_opcode, r_func7;
    logic [2:0]        r_func3;
    logic [XLEN-1:0]   w_sel_data1, w_sel_data2;
    logic [6:0]        w_sel_opcode, w_sel_func7;
    logic [2:0]        w_sel_func3;

    // Grant only exists in IDLE; ready is suppressed while reset is asserted.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        if (r_state == StIdle && rst_ni) begin
            case (bus.req_valid_i)
                2'b11: begin
                    w_gnt_valid = 1'b1;
                    w_gnt_idx   = ~r_last_grant;
                end
                2'b01: w_gnt_valid = 1'b1;
                2'b10: begin
                    w_gnt_valid = 1'b1;
                    w_gnt_idx   = IdxW'(1);
                end
                default: w_gnt_valid = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_sel_data1  = w_gnt_idx[0] ? bus.req_data1_i[XLEN +: XLEN] : bus.req_data1_i[0 +: XLEN];
        w_sel_data2  = w_gnt_idx[0] ? bus.req_data2_i[XLEN +: XLEN] : bus.req_data2_i[0 +: XLEN];
        w_sel_opcode = w_gnt_idx[0] ? bus.req_opcode_i[7 +: 7] : bus.req_opcode_i[0 +: 7];
        w_sel_func3  = w_gnt_idx[0] ? bus.req_func3_i[3 +: 3] : bus.req_func3_i[0 +: 3];
        w_sel_func7  = w_gnt_idx[0] ? bus.req_func7_i[7 +: 7] : bus.req_func7_i[0 +: 7];
    end

    always_comb begin
        w_state_next     = r_state;
        bus.req_ready_o  = '0;
        bus.rsp_valid_o  = '0;
        bus.rsp_result_o = r_result;
        if (w_gnt_valid) begin
            bus.req_ready_o[w_gnt_idx] = 1'b1;
        end
        case (r_state)
            StIdle: if (w_gnt_valid) w_state_next = StExec;
            StExec: w_state_next = StResp;
            StResp: begin
                bus.rsp_valid_o[r_owner] = 1'b1;
                if (bus.rsp_ready_i[r_owner]) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= StIdle;
            r_owner      <= '0;
            r_last_grant <= IdxW'(1);
            r_data1      <= '0;
            r_data2      <= '0;
            r_opcode     <= '0;
            r_func3      <= '0;
            r_func7      <= '0;
            r_result     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_gnt_valid) begin
                r_owner      <= w_gnt_idx;
                r_last_grant <= w_gnt_idx;
                r_data1      <= w_sel_data1;
                r_data2      <= w_sel_data2;
                r_opcode     <= w_sel_opcode;
                r_func3      <= w_sel_func3;
                r_func7      <= w_sel_func7;
            end
            if (r_state == StExec) begin
                r_result <= alu_result_i;
            end
        end
    end

    assign alu_data1_o  = r_data1;
    assign alu_data2_o  = r_data2;
    assign alu_opcode_o = r_opcode;
    assign alu_func3_o  = r_func3;
    assign alu_func7_o  = r_func7;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small R-type alu stub on the alu ports.
module tb_alu_arbiter;
    localparam logic [6:0] OpR   = 7'b0110011;
    localparam logic [6:0] F7Sub = 7'b0100000;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] alu_data1, alu_data2, alu_result;
    logic [6:0]  alu_opcode, alu_func7;
    logic [2:0]  alu_func3;
    int          total = 0;
    int          bad   = 0;

    alu_arbiter_if #(.XLEN(32), .NUM_REQ(2)) bus ();

    alu_arbiter #(.XLEN(32), .NUM_REQ(2)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .bus         (bus),
        .alu_data1_o (alu_data1),
        .alu_data2_o (alu_data2),
        .alu_opcode_o(alu_opcode),
        .alu_func3_o (alu_func3),
        .alu_func7_o (alu_func7),
        .alu_result_i(alu_result)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        alu_result = '0;
        if (alu_opcode == OpR) begin
            case (alu_func3)
                3'b000:  alu_result = (alu_func7 == F7Sub) ? alu_data1 - alu_data2
                                                           : alu_data1 + alu_data2;
                3'b100:  alu_result = alu_data1 ^ alu_data2;
                3'b110:  alu_result = alu_data1 | alu_data2;
                3'b111:  alu_result = alu_data1 & alu_data2;
                default: alu_result = '0;
            endcase
        end
    end

    task automatic next();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    task automatic drive_req(input int n, input logic [31:0] d1, input logic [31:0] d2,
                             input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        bus.req_data1_i[n*32 +: 32] = d1;
        bus.req_data2_i[n*32 +: 32] = d2;
        bus.req_opcode_i[n*7 +: 7]  = op;
        bus.req_func3_i[n*3 +: 3]   = f3;
        bus.req_func7_i[n*7 +: 7]   = f7;
        bus.req_valid_i[n]          = 1'b1;
    endtask

    task automatic clear_inputs();
        bus.req_valid_i  = '0;
        bus.req_data1_i  = '0;
        bus.req_data2_i  = '0;
        bus.req_opcode_i = '0;
        bus.req_func3_i  = '0;
        bus.req_func7_i  = '0;
        bus.rsp_ready_i  = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_ni = 1'b0;
        next();
        next();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_ni = 1'b0;
        bus.req_valid_i = 2'b11;
        mid();
        total++; if (bus.req_ready_o !== 2'b00) begin bad++;
            $display("FAIL reset_ready got=%b want=00", bus.req_ready_o); end
        total++; if (bus.rsp_valid_o !== 2'b00) begin bad++;
            $display("FAIL reset_rsp_valid got=%b want=00", bus.rsp_valid_o); end
        total++; if (bus.rsp_result_o !== 32'd0) begin bad++;
            $display("FAIL reset_result got=%0h want=0", bus.rsp_result_o); end
        total++; if ({alu_data1, alu_data2, alu_opcode, alu_func3, alu_func7} !== '0) begin bad++;
            $display("FAIL reset_alu got=%0h/%0h/%b want=0", alu_data1, alu_data2, alu_opcode); end
        clear_inputs();
        next();
        rst_ni = 1'b1;
    endtask

    task automatic test_single_add();
        drive_req(0, 32'd6, 32'd5, OpR, 3'b000, 7'd0);
        mid();
        total++; if (bus.req_ready_o !== 2'b01) begin bad++;
            $display("FAIL single_ready got=%b want=01", bus.req_ready_o); end
        next();
        bus.req_valid_i = '0;
        mid();
        total++; if (bus.req_ready_o !== 2'b00) begin bad++;
            $display("FAIL single_ready_pulse got=%b want=00", bus.req_ready_o); end
        total++; if (alu_opcode !== OpR || alu_data1 !== 32'd6 || alu_data2 !== 32'd5) begin bad++;
            $display("FAIL single_alu got=%b/%0d/%0d want=0110011/6/5", alu_opcode, alu_data1,
                     alu_data2); end
        total++; if (bus.rsp_valid_o !== 2'b00) begin bad++;
            $display("FAIL single_exec_rsp got=%b want=00", bus.rsp_valid_o); end
        next();
        mid();
        total++; if (bus.rsp_valid_o !== 2'b01) begin bad++;
            $display("FAIL single_rsp_valid got=%b want=01", bus.rsp_valid_o); end
        total++; if (bus.rsp_result_o !== 32'd11) begin bad++;
            $display("FAIL single_result got=%0d want=11", bus.rsp_result_o); end
        bus.rsp_ready_i = 2'b01;
        next();
        mid();
        total++; if (bus.rsp_valid_o !== 2'b00) begin bad++;
            $display("FAIL single_rsp_drop got=%b want=00", bus.rsp_valid_o); end
        total++; if (alu_opcode !== OpR) begin bad++;
            $display("FAIL single_alu_hold got=%b want=0110011", alu_opcode); end
        bus.rsp_ready_i = '0;
        next();
    endtask

    task automatic test_and_func7();
        drive_req(0, 32'd6, 32'd5, OpR, 3'b111, F7Sub);
        mid();
        next();
        bus.req_valid_i = '0;
        mid();
        total++; if (alu_func7 !== F7Sub || alu_func3 !== 3'b111) begin bad++;
            $display("FAIL and_exec_func got=%b/%b want=0100000/111", alu_func7, alu_func3); end
        next();
        mid();
        total++; if (bus.rsp_result_o !== 32'd4) begin bad++;
            $display("FAIL and_result got=%0d want=4", bus.rsp_result_o); end
        bus.rsp_ready_i = 2'b01;
        next();
        bus.rsp_ready_i = '0;
    endtask

    task automatic test_simultaneous();
        apply_reset();
        drive_req(0, 32'd6, 32'd5, OpR, 3'b000, 7'd0);
        drive_req(1, 32'd10, 32'd3, OpR, 3'b000, 7'd0);
        mid();
        total++; if (bus.req_ready_o !== 2'b01) begin bad++;
            $display("FAIL simul_first_grant got=%b want=01", bus.req_ready_o); end
        next();
        bus.req_valid_i[0] = 1'b0;
        mid();
        total++; if (bus.req_ready_o !== 2'b00) begin bad++;
            $display("FAIL simul_exec_ready got=%b want=00", bus.req_ready_o); end
        next();
        mid();
        total++; if (bus.rsp_valid_o !== 2'b01 || bus.rsp_result_o !== 32'd11) begin bad++;
            $display("FAIL simul_rsp0 got=%b/%0d want=01/11", bus.rsp_valid_o, bus.rsp_result_o);
        end
        bus.rsp_ready_i = 2'b11;
        next();
        mid();
        total++; if (bus.req_ready_o !== 2'b10) begin bad++;
            $display("FAIL simul_second_grant got=%b want=10", bus.req_ready_o); end
        next();
        bus.req_valid_i[1] = 1'b0;
        mid();
        next();
        mid();
        total++; if (bus.rsp_valid_o !== 2'b10 || bus.rsp_result_o !== 32'd13) begin bad++;
            $display("FAIL simul_rsp1 got=%b/%0d want=10/13", bus.rsp_valid_o, bus.rsp_result_o);
        end
        next();
        bus.rsp_ready_i = '0;
    endtask

    task automatic test_contention();
        int         cnt [2];
        int         g;
        logic [1:0] want;
        cnt[0] = 0;
        cnt[1] = 0;
        bus.rsp_ready_i = 2'b11;
        drive_req(0, 32'd0, 32'd7, OpR, 3'b000, 7'd0);
        drive_req(1, 32'd100, 32'd7, OpR, 3'b000, 7'd0);
        for (int i = 0; i < 6; i++) begin
            g    = i % 2;
            want = 2'b01 << g;
            mid();
            total++; if (bus.req_ready_o !== want) begin bad++;
                $display("FAIL contend_grant op=%0d got=%b want=%b", i, bus.req_ready_o, want); end
            next();
            cnt[g]++;
            drive_req(g, 32'(100 * g + cnt[g]), 32'd7, OpR, 3'b000, 7'd0);
            mid();
            next();
            mid();
            total++; if (bus.rsp_valid_o !== want) begin bad++;
                $display("FAIL contend_rsp op=%0d got=%b want=%b", i, bus.rsp_valid_o, want); end
            total++; if (bus.rsp_result_o !== 32'(100 * g + cnt[g] - 1 + 7)) begin bad++;
                $display("FAIL contend_result op=%0d got=%0d want=%0d", i, bus.rsp_result_o,
                         100 * g + cnt[g] - 1 + 7); end
            next();
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        drive_req(0, 32'd20, 32'd22, OpR, 3'b000, 7'd0);
        mid();
        total++; if (bus.req_ready_o !== 2'b01) begin bad++;
            $display("FAIL bp_grant got=%b want=01", bus.req_ready_o); end
        next();
        bus.req_valid_i[0] = 1'b0;
        drive_req(1, 32'd9, 32'd1, OpR, 3'b000, 7'd0);
        mid();
        next();
        for (int k = 0; k < 5; k++) begin
            bus.rsp_ready_i = 2'b10;
            mid();
            total++; if (bus.rsp_valid_o !== 2'b01 || bus.rsp_result_o !== 32'd42) begin bad++;
                $display("FAIL bp_hold cyc=%0d got=%b/%0d want=01/42", k, bus.rsp_valid_o,
                         bus.rsp_result_o); end
            total++; if (bus.req_ready_o !== 2'b00) begin bad++;
                $display("FAIL bp_no_ready cyc=%0d got=%b want=00", k, bus.req_ready_o); end
            next();
        end
        bus.rsp_ready_i = 2'b01;
        next();
        mid();
        total++; if (bus.req_ready_o !== 2'b10 || bus.rsp_valid_o !== 2'b00) begin bad++;
            $display("FAIL bp_release got=%b/%b want=10/00", bus.req_ready_o, bus.rsp_valid_o);
        end
        bus.rsp_ready_i = '0;
        next();
        bus.req_valid_i[1] = 1'b0;
        mid();
        next();
        mid();
        total++; if (bus.rsp_valid_o !== 2'b10 || bus.rsp_result_o !== 32'd10) begin bad++;
            $display("FAIL bp_rsp1 got=%b/%0d want=10/10", bus.rsp_valid_o, bus.rsp_result_o); end
        bus.rsp_ready_i = 2'b10;
        next();
        bus.rsp_ready_i = '0;
    endtask

    task automatic test_reset_mid();
        drive_req(0, 32'd1, 32'd2, OpR, 3'b000, 7'd0);
        mid();
        next();
        bus.req_valid_i = '0;
        mid();
        rst_ni = 1'b0;
        #1;
        total++; if (alu_data1 !== 32'd0 || alu_opcode !== 7'd0 || bus.rsp_valid_o !== 2'b00)
            begin bad++;
            $display("FAIL rst_exec got=%0d/%b/%b want=0/0/00", alu_data1, alu_opcode,
                     bus.rsp_valid_o); end
        next();
        rst_ni = 1'b1;
        drive_req(1, 32'd4, 32'd4, OpR, 3'b000, 7'd0);
        mid();
        total++; if (bus.req_ready_o !== 2'b10) begin bad++;
            $display("FAIL rst_single_grant got=%b want=10", bus.req_ready_o); end
        next();
        bus.req_valid_i = '0;
        mid();
        next();
        mid();
        total++; if (bus.rsp_valid_o !== 2'b10 || bus.rsp_result_o !== 32'd8) begin bad++;
            $display("FAIL rst_pre_resp got=%b/%0d want=10/8", bus.rsp_valid_o, bus.rsp_result_o);
        end
        rst_ni = 1'b0;
        #1;
        total++; if (bus.rsp_valid_o !== 2'b00 || bus.rsp_result_o !== 32'd0 || alu_data1 !== 32'd0)
            begin bad++;
            $display("FAIL rst_resp got=%b/%0d/%0d want=00/0/0", bus.rsp_valid_o,
                     bus.rsp_result_o, alu_data1); end
        next();
        rst_ni = 1'b1;
        drive_req(0, 32'd6, 32'd5, OpR, 3'b000, 7'd0);
        drive_req(1, 32'd10, 32'd3, OpR, 3'b000, 7'd0);
        mid();
        total++; if (bus.rsp_valid_o !== 2'b00) begin bad++;
            $display("FAIL rst_no_partial got=%b want=00", bus.rsp_valid_o); end
        total++; if (bus.req_ready_o !== 2'b01) begin bad++;
            $display("FAIL rst_first_grant got=%b want=01", bus.req_ready_o); end
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_and_func7();
        test_simultaneous();
        test_contention();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
